fdiv_issue_queue: RTL and testbench
===================================

// Module: fdiv_issue_queue
// PURPOSE
// - Upstream feeder for the single-precision FP divider. Buffers divide requests {a, b, tag} in an in-order FIFO.
// - Screens IEEE-754 special operands and resolves them locally, without using the divider.
// - Issues normal operand pairs to the divider one at a time and returns every quotient, in request order, on a valid/ready result port.
// PARAMETERS
// DEPTH   4   request FIFO entries (power of 2, >=2)
// TAG_W   4   width of the opaque request tag, returned unchanged with the result
// PORTS
// clk        in   1      clock; all logic on posedge
// rst        in   1      asynchronous reset, active-low
// req_valid  in   1      request present
// req_ready  out  1      FIFO not full
// req_a      in   32     dividend, IEEE-754 single
// req_b      in   32     divisor, IEEE-754 single
// req_tag    in   TAG_W  request tag
// div_a      out  32     dividend to divider
// div_b      out  32     divisor to divider
// div_start  out  1      divider start
// div_enable out  1      divider enable
// div_q      in   32     divider quotient
// div_busy   in   1      divider computing
// div_stall  in   1      divider not ready to accept operands
// res_valid  out  1      result present
// res_ready  in   1      consumer accepts result
// res_q      out  32     quotient
// res_tag    out  TAG_W  tag of the originating request
// res_dz     out  1      divide-by-zero flag (finite nonzero / 0)
// res_nv     out  1      invalid flag (0/0, inf/inf, any NaN operand)
// BEHAVIOUR
// - Reset: FIFO empty; FSM=IDLE; req_ready=1; res_valid=0; div_start=0; div_enable=0; div_a, div_b, res_q, res_tag, res_dz, res_nv = 0.
// - Enqueue when req_valid && req_ready. A simultaneous pop on a full FIFO does NOT raise req_ready in that cycle.
// - Pointers wrap modulo DEPTH. Full/empty are derived from a count of width clog2(DEPTH)+1.
// - FSM states: IDLE, CHECK, ISSUE, WAIT, HOLD.
//   - IDLE: FIFO non-empty -> CHECK.
//   - CHECK: classify head, 1 cycle.
//     - Special case: load res_*, pop head, go to HOLD.
//     - Otherwise: drive div_a/div_b from head, go to ISSUE.
//   - ISSUE: wait for div_stall==0 && div_busy==0.
//     - Then assert div_start=1 for exactly one cycle and go to WAIT.
//     - div_a/div_b stay stable from ISSUE until WAIT exits.
//   - WAIT: result is taken in the first cycle with div_busy==0 && div_stall==0, checked no earlier than 2 cycles after div_start.
//     - On that cycle: latch div_q into res_q, pop head, go to HOLD.
//   - HOLD: res_valid=1; outputs stable until res_ready.
//     - On the handshake: if FIFO non-empty go to CHECK, else IDLE.
// - div_enable=1 in every state except IDLE.
// - Special cases, checked in this priority order (s = sign_a ^ sign_b):
//   1. Either operand NaN -> 32'h7FC00000, nv=1.
//   2. 0/0 or inf/inf -> 32'h7FC00000, nv=1.
//   3. inf/x -> {s, 8'hFF, 23'h0}.
//   4. Finite nonzero/0 -> {s, 8'hFF, 23'h0}, dz=1.
//   5. 0/x or x/inf -> {s, 31'h0}.
//   - Denormal operands are not special. They are forwarded to the divider unchanged.
// - Ordering: one request is in flight at a time, so results are strictly in request order.
// - Throughput: the consumer may hold res_ready low indefinitely. New enqueues are still accepted until the FIFO is full.
// - Reset mid-operation (rst low in any state): immediate return to reset values; the in-flight divide is abandoned.
// STRUCTURE
// - Shared package fdiv_pkg:
//   - FP32 field localparams: SIGN=31, EXP 30:23, MAN 22:0.
//   - QNAN=32'h7FC00000.
//   - fsm state encoding.
//   - fp32 classifier function returning {is_nan, is_inf, is_zero}.
// - One sub-module: fdiv_req_fifo, a parameterised sync FIFO (DEPTH, width 64+TAG_W) exposing push/pop/full/empty/head.
// - FSM, classifier and result register live in the top.
// TESTING
// - Normal path: c396d200/c0100000 tag 1 -> res_q=43061000, tag 1, dz=0, nv=0, with exactly one div_start pulse.
// - Back-to-back in-order: enqueue 40ae0000/bec00000 (tag 2), then 42e88000/41780000 (tag 3), res_ready=1 -> c1680000 tag 2, then 40f00000 tag 3.
// - Special bypass: 3f800000/00000000 -> 7f800000 dz=1; 00000000/00000000 -> 7fc00000 nv=1; 7f800000/c0000000 -> ff800000. No div_start in any of these.
// - Backpressure: res_ready=0 with 6 requests offered -> req_ready drops after DEPTH (4) accepts beyond the one held; all drain in order once res_ready=1.
// - Divider stall: div_stall forced high 10 cycles in ISSUE -> div_start held off, div_a/div_b stable, start issued 1 cycle after stall clears.
// - Reset in WAIT: rst low for 1 cycle -> res_valid=0, req_ready=1, FIFO empty; a fresh request completes correctly afterwards.

Source files
------------

// File: rtl/fdiv_pkg.sv
// Shared definitions for the FP divider issue queue: FP32 field positions,
// canonical quiet NaN, controller state encoding and an operand classifier.
package fdiv_pkg;

  localparam int unsigned FP_W   = 32;
  localparam int unsigned SIGN   = 31;
  localparam int unsigned EXP_HI = 30;
  localparam int unsigned EXP_LO = 23;
  localparam int unsigned MAN_HI = 22;
  localparam int unsigned MAN_LO = 0;

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

  // Denormals classify as none of the three and therefore go to the divider.
  function automatic fp_class_t fp32_classify(input logic [FP_W-1:0] x);
    fp_class_t c;
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    exp_ones  = (x[EXP_HI:EXP_LO] == 8'hFF);
    exp_zero  = (x[EXP_HI:EXP_LO] == 8'h00);
    man_zero  = (x[MAN_HI:MAN_LO] == 23'h0);
    c.is_nan  = exp_ones && !man_zero;
    c.is_inf  = exp_ones && man_zero;
    c.is_zero = exp_zero && man_zero;
    return c;
  endfunction

endpackage

// File: rtl/fdiv_req_fifo.sv
// Synchronous request FIFO; head is valid whenever empty is low.
module fdiv_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 68
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fdiv_issue_queue.sv
// In-order issue queue for the FP32 divider: resolves IEEE special operands
// locally and serialises normal divides, returning results in request order.
module fdiv_issue_queue
  import fdiv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [FP_W-1:0]  req_a,
  input  logic [FP_W-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [FP_W-1:0]  div_a,
  output logic [FP_W-1:0]  div_b,
  output logic             div_start,
  output logic             div_enable,
  input  logic [FP_W-1:0]  div_q,
  input  logic             div_busy,
  input  logic             div_stall,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [FP_W-1:0]  res_q,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_dz,
  output logic             res_nv
);

  localparam int unsigned ENTRY_W  = 2 * FP_W + TAG_W;
  localparam int unsigned WAIT_W   = 2;
  localparam int unsigned WAIT_CYC = 2;

  state_t             state, state_n;
  logic [FP_W-1:0]    div_a_n, div_b_n, res_q_n;
  logic [TAG_W-1:0]   res_tag_n;
  logic               div_start_n, div_enable_n, res_valid_n, res_dz_n, res_nv_n;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_n;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0] head;
  logic [FP_W-1:0]    head_a, head_b;
  logic [TAG_W-1:0]   head_tag;

  fp_class_t          cls_a, cls_b;
  logic               sgn;
  logic               spec_hit, spec_dz, spec_nv;
  logic [FP_W-1:0]    spec_q;

  fdiv_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (fifo_pop),
    .din   ({req_a, req_b, req_tag}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign req_ready = !fifo_full;
  assign head_a    = head[ENTRY_W-1 -: FP_W];
  assign head_b    = head[TAG_W +: FP_W];
  assign head_tag  = head[TAG_W-1:0];
  assign cls_a     = fp32_classify(head_a);
  assign cls_b     = fp32_classify(head_b);
  assign sgn       = head_a[SIGN] ^ head_b[SIGN];

  // Special-operand screen in priority order; spec_hit low means use the divider.
  always_comb begin
    spec_hit = 1'b1;
    spec_q   = QNAN;
    spec_dz  = 1'b0;
    spec_nv  = 1'b0;
    if (cls_a.is_nan || cls_b.is_nan) begin
      spec_nv = 1'b1;
    end else if ((cls_a.is_zero && cls_b.is_zero) || (cls_a.is_inf && cls_b.is_inf)) begin
      spec_nv = 1'b1;
    end else if (cls_a.is_inf) begin
      spec_q = {sgn, 8'hFF, 23'h0};
    end else if (cls_b.is_zero) begin
      spec_q  = {sgn, 8'hFF, 23'h0};
      spec_dz = 1'b1;
    end else if (cls_a.is_zero || cls_b.is_inf) begin
      spec_q = {sgn, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      div_a      <= '0;
      div_b      <= '0;
      div_start  <= 1'b0;
      div_enable <= 1'b0;
      res_valid  <= 1'b0;
      res_q      <= '0;
      res_tag    <= '0;
      res_dz     <= 1'b0;
      res_nv     <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_n;
      div_a      <= div_a_n;
      div_b      <= div_b_n;
      div_start  <= div_start_n;
      div_enable <= div_enable_n;
      res_valid  <= res_valid_n;
      res_q      <= res_q_n;
      res_tag    <= res_tag_n;
      res_dz     <= res_dz_n;
      res_nv     <= res_nv_n;
      wait_cnt   <= wait_cnt_n;
    end
  end

  // wait_cnt reaches WAIT_CYC two cycles after div_start is visible to the divider.
  always_comb begin
    state_n     = state;
    div_a_n     = div_a;
    div_b_n     = div_b;
    div_start_n = 1'b0;
    res_valid_n = res_valid;
    res_q_n     = res_q;
    res_tag_n   = res_tag;
    res_dz_n    = res_dz;
    res_nv_n    = res_nv;
    wait_cnt_n  = wait_cnt;
    fifo_pop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) state_n = CHECK;
      end
      CHECK: begin
        if (spec_hit) begin
          res_valid_n = 1'b1;
          res_q_n     = spec_q;
          res_tag_n   = head_tag;
          res_dz_n    = spec_dz;
          res_nv_n    = spec_nv;
          fifo_pop    = 1'b1;
          state_n     = HOLD;
        end else begin
          div_a_n = head_a;
          div_b_n = head_b;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!div_stall && !div_busy) begin
          div_start_n = 1'b1;
          wait_cnt_n  = '0;
          state_n     = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt != WAIT_W'(WAIT_CYC)) begin
          wait_cnt_n = wait_cnt + WAIT_W'(1);
        end else if (!div_busy && !div_stall) begin
          res_valid_n = 1'b1;
          res_q_n     = div_q;
          res_tag_n   = head_tag;
          res_dz_n    = 1'b0;
          res_nv_n    = 1'b0;
          fifo_pop    = 1'b1;
          state_n     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          state_n     = fifo_empty ? IDLE : CHECK;
        end
      end
      default: state_n = IDLE;
    endcase
    div_enable_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_fdiv_issue_queue.sv
// Randomised and directed bench for fdiv_issue_queue against a queue-based
// reference model and a behavioural divider with variable latency and stall.
module tb_fdiv_issue_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_a = '0, req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      div_a, div_b, div_q;
  logic             div_start, div_enable, div_busy, div_stall;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_q;
  logic [TAG_W-1:0] res_tag;
  logic             res_dz, res_nv;

  always #5 clk = ~clk;

  fdiv_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_enable(div_enable),
    .div_q(div_q), .div_busy(div_busy), .div_stall(div_stall),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_q(res_q), .res_tag(res_tag), .res_dz(res_dz), .res_nv(res_nv)
  );

  typedef struct packed {
    logic [31:0]      a, b, q;
    logic [TAG_W-1:0] tag;
    logic             dz, nv, special;
  } ent_t;

  int   n_checks = 0;
  int   n_fail = 0;
  ent_t expq[$];
  ent_t got[$];
  int   outstanding = 0;
  int   starts = 0;
  int   total_starts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference: IEEE special-case rules applied to the raw fields.
  function automatic ent_t model(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    ent_t e;
    logic na, nb, ia, ib, za, zb, s;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    za = (a[30:0] == 0);
    zb = (b[30:0] == 0);
    s  = a[31] ^ b[31];
    e = '0;
    e.a = a; e.b = b; e.tag = tag; e.special = 1'b1;
    if (na || nb || (za && zb) || (ia && ib)) begin e.q = 32'h7FC00000; e.nv = 1'b1; end
    else if (ia)             e.q = {s, 8'hFF, 23'h0};
    else if (zb)             begin e.q = {s, 8'hFF, 23'h0}; e.dz = 1'b1; end
    else if (za || ib)       e.q = {s, 31'h0};
    else                     begin e.q = div_fn(a, b); e.special = 1'b0; end
    return e;
  endfunction

  // Divider behaviour: exact quotients for the named vectors, a fixed scramble otherwise.
  function automatic logic [31:0] div_fn(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] k;
    k = {a, b};
    case (k)
      64'hc396d200_c0100000: return 32'h43061000;
      64'h40ae0000_bec00000: return 32'hc1680000;
      64'h42e88000_41780000: return 32'h40f00000;
      default:               return (a ^ {b[7:0], b[31:8]}) + 32'h01234567;
    endcase
  endfunction

  // Behavioural divider with variable latency and optional random stall.
  int   lat_min = 1, lat_max = 4, lat_cnt = 0;
  bit   stall_rand = 1'b0, stall_force = 1'b0;
  logic stall_q;
  logic [31:0] la, lb;
  assign div_stall = stall_force || stall_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_busy <= 1'b0; div_q <= '0; stall_q <= 1'b0; lat_cnt <= 0; la <= '0; lb <= '0;
    end else begin
      stall_q <= stall_rand && ($urandom_range(0, 3) == 0);
      if (div_start && !div_busy) begin
        la <= div_a; lb <= div_b; div_q <= 32'hDEADBEEF;
        div_busy <= 1'b1;
        lat_cnt <= int'($urandom_range(lat_min, lat_max));
      end else if (div_busy) begin
        if (lat_cnt <= 1) begin div_busy <= 1'b0; div_q <= div_fn(la, lb); end
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  bit rr_rand = 1'b0;
  bit rr_val = 1'b1;
  initial forever begin
    @(posedge clk); #1;
    res_ready = rr_rand ? ($urandom_range(0, 2) != 0) : rr_val;
  end

  // Compare process: every cycle, sampled on the falling edge.
  logic        p_valid = 0, p_ready = 0, p_dz = 0, p_nv = 0, p_start = 0, pending = 0, p_pending = 0;
  logic [31:0] p_q = 0, p_da = 0, p_db = 0;
  logic [TAG_W-1:0] p_tag = 0;

  always @(negedge clk) begin
    if (!rst) begin
      expq.delete(); outstanding = 0; starts = 0;
      p_valid = 0; p_ready = 0; p_start = 0; pending = 0; p_pending = 0;
    end else begin
      if (res_valid && !p_valid) begin
        outstanding--;
        pending = 0;
        check("result has request", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0)
          check("div_start count", 64'(starts), expq[0].special ? 64'd0 : 64'd1);
      end
      if (p_valid && !p_ready) begin
        check("hold valid", 64'(res_valid), 64'd1);
        check("hold q", 64'(res_q), 64'(p_q));
        check("hold tag/flags", 64'({res_tag, res_dz, res_nv}), 64'({p_tag, p_dz, p_nv}));
      end
      if (pending && p_pending)
        check("div operands stable", {div_a, div_b}, {p_da, p_db});
      check("req_ready", 64'(req_ready), 64'(outstanding < int'(DEPTH)));
      if (outstanding == 0 && !res_valid) check("div_enable idle", 64'(div_enable), 64'd0);
      if (res_valid || div_start) check("div_enable active", 64'(div_enable), 64'd1);
      if (div_start) begin
        total_starts++;
        check("div_start single cycle", 64'(p_start), 64'd0);
        check("start has request", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) begin
          check("start for normal op", 64'(expq[0].special), 64'd0);
          check("start operands", {div_a, div_b}, {expq[0].a, expq[0].b});
        end
        starts++;
        pending = 1;
      end
      if (res_valid && res_ready && expq.size() > 0) begin
        check("res_q", 64'(res_q), 64'(expq[0].q));
        check("res_tag/dz/nv", 64'({res_tag, res_dz, res_nv}), 64'({expq[0].tag, expq[0].dz, expq[0].nv}));
        got.push_back('{a: 32'h0, b: 32'h0, q: res_q, tag: res_tag, dz: res_dz, nv: res_nv, special: 1'b0});
        void'(expq.pop_front());
        starts = 0;
      end
      if (req_valid && req_ready) begin
        expq.push_back(model(req_a, req_b, req_tag));
        outstanding++;
      end
      p_valid = res_valid; p_ready = res_ready; p_q = res_q; p_tag = res_tag;
      p_dz = res_dz; p_nv = res_nv; p_start = div_start;
      p_pending = pending; p_da = div_a; p_db = div_b;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    int t;
    t = 0;
    req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      t++;
      if (t > 500) begin timeout_fail("send"); break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int t;
    t = 0;
    while (expq.size() != 0 || res_valid || req_valid) begin
      @(negedge clk);
      t++;
      if (t > bound) begin timeout_fail("drain"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_got(input int idx, input logic [31:0] q, input logic [TAG_W-1:0] tag,
                           input logic dz, input logic nv);
    check("directed result present", 64'(idx < got.size()), 64'd1);
    if (idx < got.size()) begin
      check("directed q", 64'(got[idx].q), 64'(q));
      check("directed tag/dz/nv", 64'({got[idx].tag, got[idx].dz, got[idx].nv}), 64'({tag, dz, nv}));
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    case ($urandom_range(0, 15))
      0:  x = 32'h00000000;
      1:  x = 32'h80000000;
      2:  x = 32'h7F800000;
      3:  x = 32'hFF800000;
      4:  x = 32'h7FC00000;
      5:  x = 32'hFF800001;
      6:  x = 32'h00000001;
      7:  x = 32'h807FFFFF;
      default: x = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
    return x;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s0, acc;
    ent_t m;

    // Model pinned to hand-computed values.
    m = model(32'h3f800000, 32'h00000000, 4'd0);
    check("model 1/0", 64'({m.q, m.dz, m.nv, m.special}), 64'({32'h7f800000, 1'b1, 1'b0, 1'b1}));
    m = model(32'h00000000, 32'h00000000, 4'd0);
    check("model 0/0", 64'({m.q, m.dz, m.nv}), 64'({32'h7fc00000, 1'b0, 1'b1}));
    m = model(32'h7f800000, 32'hc0000000, 4'd0);
    check("model inf/-2", 64'({m.q, m.dz, m.nv}), 64'({32'hff800000, 1'b0, 1'b0}));
    m = model(32'h00000001, 32'h3f800000, 4'd0);
    check("model denormal not special", 64'(m.special), 64'd0);

    // Reset values.
    @(negedge clk);
    check("rst res_valid/req_ready", 64'({res_valid, req_ready, div_start, div_enable}), 64'(4'b0100));
    check("rst div_a/div_b", {div_a, div_b}, 64'd0);
    check("rst res fields", 64'({res_q, res_tag, res_dz, res_nv}), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // Normal path, one start pulse.
    base = got.size(); s0 = total_starts;
    send(32'hc396d200, 32'hc0100000, 4'd1);
    drain(200);
    check_got(base, 32'h43061000, 4'd1, 1'b0, 1'b0);
    check("normal start pulses", 64'(total_starts - s0), 64'd1);

    // Back-to-back in order.
    base = got.size();
    send(32'h40ae0000, 32'hbec00000, 4'd2);
    send(32'h42e88000, 32'h41780000, 4'd3);
    drain(200);
    check_got(base, 32'hc1680000, 4'd2, 1'b0, 1'b0);
    check_got(base + 1, 32'h40f00000, 4'd3, 1'b0, 1'b0);

    // Special bypass, no divider use.
    base = got.size(); s0 = total_starts;
    send(32'h3f800000, 32'h00000000, 4'd4);
    send(32'h00000000, 32'h00000000, 4'd5);
    send(32'h7f800000, 32'hc0000000, 4'd6);
    drain(200);
    check_got(base, 32'h7f800000, 4'd4, 1'b1, 1'b0);
    check_got(base + 1, 32'h7fc00000, 4'd5, 1'b0, 1'b1);
    check_got(base + 2, 32'hff800000, 4'd6, 1'b0, 1'b0);
    check("special start pulses", 64'(total_starts - s0), 64'd0);

    // Backpressure: one held plus DEPTH queued, sixth refused.
    rr_val = 1'b0;
    @(posedge clk); #1;
    base = got.size(); acc = 0;
    for (int i = 0; i < 6; i++) begin
      int t;
      t = 0;
      req_a = 32'h40400000 + 32'(i); req_b = 32'h3fc00000; req_tag = TAG_W'(i + 8); req_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (req_ready) begin acc++; break; end
        t++;
        if (t > 40) break;
      end
      if (req_ready) begin @(posedge clk); #1; req_valid = 1'b0; end
    end
    check("backpressure accepts", 64'(acc), 64'd5);
    check("backpressure req_ready low", 64'(req_ready), 64'd0);
    rr_val = 1'b1;
    send(req_a, req_b, req_tag);
    drain(400);
    for (int i = 0; i < 6; i++)
      check_got(base + i, div_fn(32'h40400000 + 32'(i), 32'h3fc00000), TAG_W'(i + 8), 1'b0, 1'b0);

    // Divider stall held in ISSUE.
    stall_force = 1'b1;
    send(32'h40ae0000, 32'hbec00000, 4'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall no start", 64'(div_start), 64'd0);
      check("stall operands", {div_a, div_b}, 64'h40ae0000_bec00000);
    end
    @(posedge clk); #1; stall_force = 1'b0;
    @(negedge clk); check("start not before edge", 64'(div_start), 64'd0);
    @(negedge clk); check("start after stall clears", 64'(div_start), 64'd1);
    drain(200);

    // Reset while waiting on the divider.
    lat_min = 15; lat_max = 15;
    send(32'hc396d200, 32'hc0100000, 4'd9);
    begin
      int t;
      t = 0;
      while (!div_start && t < 100) begin @(negedge clk); t++; end
      if (!div_start) timeout_fail("wait div_start");
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid reset state", 64'({res_valid, req_ready, div_start, div_enable}), 64'(4'b0100));
    @(posedge clk); #1; rst = 1'b1;
    lat_min = 1; lat_max = 4;
    @(posedge clk); #1;
    base = got.size();
    send(32'hc396d200, 32'hc0100000, 4'd10);
    drain(200);
    check_got(base, 32'h43061000, 4'd10, 1'b0, 1'b0);
    check("single result after reset", 64'(got.size() - base), 64'd1);

    // Randomised traffic with random stall, latency and consumer backpressure.
    rr_rand = 1'b1; stall_rand = 1'b1; lat_min = 1; lat_max = 6;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(rand_op(), rand_op(), TAG_W'($urandom));
    end
    rr_rand = 1'b0; rr_val = 1'b1;
    drain(2000);
    stall_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
